mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs and drives a data-memory port with a req/ready handshake.
- Stalls the upstream pipeline while a variable-latency access is outstanding.
- Registers the stage result into the MEM/WB pipeline register feeding writeback.

Parameters:
- DATA_W, 32, data/ALU word width
- REG_ADDR_W, 5, register-file address width
- CNT_W, 32, stall performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- MEM_ALU_out  in  DATA_W  ALU result / memory byte address
- MEM_register_read_data2  in  DATA_W  store data
- MEM_register_addr  in  REG_ADDR_W  destination register
- MEM_MemRead  in  1  load
- MEM_MemtoReg  in  1  writeback selects memory data
- MEM_MemWrite  in  1  store
- MEM_RegWrite  in  1  register write enable
- dmem_req  out  1  access request
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  DATA_W  word-aligned address
- dmem_wdata  out  DATA_W  write data
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  DATA_W  read data, valid when dmem_ready=1 and dmem_we=0
- mem_stall  out  1  hold IF/ID/EX/EX_MEM registers this cycle
- WB_ALU_out  out  DATA_W  registered ALU result
- WB_mem_read_data  out  DATA_W  registered load data
- WB_register_addr  out  REG_ADDR_W  registered destination
- WB_MemtoReg  out  1  registered
- WB_RegWrite  out  1  registered
- perf_stall_cnt  out  CNT_W  cycles spent stalled

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - All WB_* outputs and perf_stall_cnt are 0.
  - dmem_req and mem_stall are 0 in the following cycle, regardless of any pending access.
- Access condition: acc = MEM_MemRead | MEM_MemWrite. MemWrite has priority.
  - Both MemRead and MemWrite set: perform a write; the load data captured is 0.
- Data-port drive (combinational):
  - dmem_addr = {MEM_ALU_out[DATA_W-1:2], 2'b00}.
  - dmem_wdata = MEM_register_read_data2.
  - dmem_we = MEM_MemWrite.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req = acc.
    - acc=1 and dmem_ready=0: mem_stall=1; next state WAIT.
    - acc=1 and dmem_ready=1: access completes, zero wait; mem_stall=0; stay in IDLE.
    - acc=0: no request, mem_stall=0.
  - WAIT: dmem_req=1. The upstream hold keeps the address, data and control inputs stable.
    - mem_stall = ~dmem_ready.
    - dmem_ready=1: complete; next state IDLE.
- Completion is single-beat only. dmem_ready while dmem_req=0 is ignored.
- Data memory shares rst and never returns ready for a request aborted by reset.
- MEM/WB capture at every edge (not in reset):
  - Stalled cycle (mem_stall=1): insert a bubble. WB_RegWrite=0 and WB_MemtoReg=0; other WB_* fields hold their previous values.
  - Otherwise:
    - WB_ALU_out <= MEM_ALU_out.
    - WB_register_addr <= MEM_register_addr.
    - WB_MemtoReg <= MEM_MemtoReg.
    - WB_RegWrite <= MEM_RegWrite.
    - WB_mem_read_data <= dmem_rdata on a completing read, else 0.
- Latency: a load with zero wait states has its data at the WB_* outputs 1 cycle after the MEM cycle. N wait states add N cycles.
- perf_stall_cnt:
  - Increments on every edge where mem_stall=1.
  - Saturates at all-ones; no wrap.
  - Cleared only by rst.
- Non-memory instructions never stall and pass through in 1 cycle, equivalent to a plain pipeline register.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, WAIT).
  - Word-alignment mask constant.
  - Bubble control constants (RegWrite=0, MemtoReg=0).
- One sub-module, mem_wb_reg, is natural:
  - Holds the WB_* flops with a synchronous clear (rst) and a bubble input (mem_stall).
  - mem_stage instantiates it alongside the handshake FSM and counter.

Test Plan:
- ALU op, no access: MEM_ALU_out=0x0000_0010, MEM_RegWrite=1, MEM_register_addr=5 -> next cycle WB_ALU_out=0x10, WB_RegWrite=1, WB_register_addr=5; mem_stall never 1.
- Zero-wait load: MEM_MemRead=1, MEM_MemtoReg=1, MEM_ALU_out=0x0000_0046, dmem_ready=1 same cycle, dmem_rdata=0xDEAD_BEEF -> dmem_addr=0x44, dmem_we=0, mem_stall=0; next cycle WB_mem_read_data=0xDEADBEEF, WB_MemtoReg=1.
- 3-wait store: MEM_MemWrite=1, addr 0x100, data 0x1234_5678, dmem_ready asserted on the 4th cycle -> dmem_req=1 for 4 cycles, dmem_we=1, mem_stall=1 for 3 cycles, WB_RegWrite=0 in each of those 3 bubble cycles, perf_stall_cnt=3.
- Reset mid-WAIT: load pending for 2 cycles, then rst=1 for 1 cycle -> next cycle dmem_req=0, mem_stall=0, all WB_* outputs 0, perf_stall_cnt=0.
- Read+write both set, dmem_ready=1 -> dmem_we=1; next cycle WB_mem_read_data=0.
- Counter saturation: with CNT_W=4, stall 20 consecutive cycles -> perf_stall_cnt=15 and holds at 15.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   mem_state_e      : data-port handshake FSM states
//   WORD_OFS_W       : number of byte-offset bits cleared to word-align
//   WORD_OFS_CLEAR   : fill value for the cleared byte-offset bits
//   BUBBLE_*         : control values written into MEM/WB on a stall bubble
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int unsigned WORD_OFS_W = 2;
  localparam logic [WORD_OFS_W-1:0] WORD_OFS_CLEAR = '0;

  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMTOREG = 1'b0;

endpackage

// File: rtl/mem_stage_mem_wb_reg.sv
// MEM/WB pipeline register.
//   clk, rst        : clock, synchronous active-high clear
//   bubble          : insert a bubble (kill RegWrite/MemtoReg, hold data fields)
//   alu_out, mem_read_data, register_addr, MemtoReg, RegWrite : stage results
//   WB_*            : registered outputs feeding writeback
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [REG_ADDR_W-1:0] register_addr,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  output logic [DATA_W-1:0]     WB_ALU_out,
  output logic [DATA_W-1:0]     WB_mem_read_data,
  output logic [REG_ADDR_W-1:0] WB_register_addr,
  output logic                  WB_MemtoReg,
  output logic                  WB_RegWrite
);

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_ALU_out       <= '0;
      WB_mem_read_data <= '0;
      WB_register_addr <= '0;
      WB_MemtoReg      <= 1'b0;
      WB_RegWrite      <= 1'b0;
    end else if (bubble) begin
      WB_MemtoReg <= BUBBLE_MEMTOREG;
      WB_RegWrite <= BUBBLE_REGWRITE;
    end else begin
      WB_ALU_out       <= alu_out;
      WB_mem_read_data <= mem_read_data;
      WB_register_addr <= register_addr;
      WB_MemtoReg      <= MemtoReg;
      WB_RegWrite      <= RegWrite;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: drives the data-memory req/ready port from the EX/MEM
// register, stalls upstream while an access is outstanding, registers the
// result into MEM/WB and counts stalled cycles (saturating).
//   clk, rst                 : clock, synchronous active-high reset
//   MEM_*                    : EX/MEM pipeline register outputs
//   dmem_req/we/addr/wdata   : data-memory request (word-aligned address)
//   dmem_ready/rdata         : data-memory completion and load data
//   mem_stall                : hold upstream pipeline registers this cycle
//   WB_*                     : MEM/WB pipeline register outputs
//   perf_stall_cnt           : number of stalled cycles since reset
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     MEM_ALU_out,
  input  logic [DATA_W-1:0]     MEM_register_read_data2,
  input  logic [REG_ADDR_W-1:0] MEM_register_addr,
  input  logic                  MEM_MemRead,
  input  logic                  MEM_MemtoReg,
  input  logic                  MEM_MemWrite,
  input  logic                  MEM_RegWrite,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  mem_stall,
  output logic [DATA_W-1:0]     WB_ALU_out,
  output logic [DATA_W-1:0]     WB_mem_read_data,
  output logic [REG_ADDR_W-1:0] WB_register_addr,
  output logic                  WB_MemtoReg,
  output logic                  WB_RegWrite,
  output logic [CNT_W-1:0]      perf_stall_cnt
);

  mem_state_e        state;
  logic              acc;
  logic              read_done;
  logic [DATA_W-1:0] load_data;

  assign acc        = MEM_MemRead | MEM_MemWrite;
  assign dmem_addr  = {MEM_ALU_out[DATA_W-1:WORD_OFS_W], WORD_OFS_CLEAR};
  assign dmem_wdata = MEM_register_read_data2;
  assign dmem_we    = MEM_MemWrite;

  // In WAIT the upstream hold keeps acc asserted, so a single expression
  // covers both states: stall whenever a request is up and not yet ready.
  always_comb begin
    dmem_req  = (state == WAIT) | acc;
    mem_stall = dmem_req & ~dmem_ready;
  end

  // Write wins when both MemRead and MemWrite are set, so no load data then.
  assign read_done = dmem_req & dmem_ready & MEM_MemRead & ~MEM_MemWrite;
  assign load_data = read_done ? dmem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (acc && !dmem_ready) state <= WAIT;
        WAIT:    if (dmem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (mem_stall && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
    end
  end

  mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mem_wb_reg (
    .clk              (clk),
    .rst              (rst),
    .bubble           (mem_stall),
    .alu_out          (MEM_ALU_out),
    .mem_read_data    (load_data),
    .register_addr    (MEM_register_addr),
    .MemtoReg         (MEM_MemtoReg),
    .RegWrite         (MEM_RegWrite),
    .WB_ALU_out       (WB_ALU_out),
    .WB_mem_read_data (WB_mem_read_data),
    .WB_register_addr (WB_register_addr),
    .WB_MemtoReg      (WB_MemtoReg),
    .WB_RegWrite      (WB_RegWrite)
  );

endmodule
